tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Two-port arbiter that shares one s3g_tx packet transmitter between the command executor (port A, responses) and an asynchronous event reporter (port B, unsolicited status packets). Each port gets a one-deep holding slot, and the arbiter issues held packets to s3g_tx in round-robin order. A new packet is issued only after the previous one has cleared tx_busy. The block sits between the executor/reporter tx interfaces and s3g_tx.

## Interface
Parameters: none.

- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- a_packet_wr  input  1  port A one-cycle write strobe
- a_payload_len  input  8  port A payload length, sampled with a_packet_wr
- a_buf0 … a_buf15  input  8 each  port A payload bytes, sampled with a_packet_wr
- a_busy  output  1  port A slot occupied
- a_drop  output  1  one-cycle pulse: port A write rejected
- b_packet_wr, b_payload_len, b_buf0 … b_buf15  input  1/8/8  port B, same meaning as port A
- b_busy, b_drop  output  1  port B, same meaning as port A
- tx_busy  input  1  s3g_tx transmitting
- tx_packet_wr  output  1  one-cycle write strobe to s3g_tx
- tx_payload_len  output  8  length to s3g_tx, valid only while tx_packet_wr=1, else 0
- tx_buf0 … tx_buf15  output  8 each  bytes to s3g_tx, valid only while tx_packet_wr=1, else 0

## Operation
- Slot capture, per port:
  - x_packet_wr=1 with slot empty (x_busy=0): latch len and the 16 bytes; slot_full←1.
  - x_packet_wr=1 with slot full: write ignored, slot contents unchanged, x_drop=1 on the next cycle.
- x_busy is the registered slot_full flag.
- FSM states: S_IDLE, S_DELAY, S_BUSY.
  - S_IDLE: if tx_busy=0 and at least one slot is full, grant a port:
    - Only one slot full: grant that port.
    - Both full: grant the port not granted last (last_grant).
    - On the grant: register the slot onto the tx_* outputs with tx_packet_wr=1 for one cycle, clear the granted slot, update last_grant, go to S_DELAY.
    - If tx_busy=1 or no slot is full: stay in S_IDLE.
  - S_DELAY: unconditional single cycle, covering the s3g_tx busy-rise latency; go to S_BUSY.
  - S_BUSY: when tx_busy=0, go to S_IDLE; otherwise stay.
  - Illegal state encoding: go to S_IDLE.
- A write arriving on the same edge the slot is issued sees x_busy=1 and is dropped.
- payload_len is passed through unmodified, including 0 and values >16. Bytes are not reordered.
- Packets are never split or merged. Each accepted write produces exactly one tx_packet_wr pulse.

## Timing
- Reset (rst=0, asynchronous) drives:
  - state=S_IDLE, both slots empty, last_grant=B (so A wins the first contention).
  - tx_packet_wr=0, tx_payload_len=0, tx_buf*=0.
  - a_busy=b_busy=0, a_drop=b_drop=0.
  - Held packets are discarded.
- Reset asserted mid-transfer: the same values as above apply immediately. After release the arbiter waits in S_IDLE for tx_busy=0.
- Latency with s3g_tx idle:
  - x_packet_wr at edge N → x_busy=1 after N.
  - tx_packet_wr=1 after N+1, for exactly one cycle; x_busy=0 after N+1.
- Minimum spacing between tx_packet_wr pulses is 3 cycles (IDLE→DELAY→BUSY→IDLE), longer while tx_busy stays high.
- tx_* outputs are registered. There is no combinational path from any input to any output.
- x_drop is registered, one cycle after the rejected strobe.
- Simultaneous x_packet_wr on A and B into empty slots: both are captured on the same edge; the grant then follows last_grant.

## Test plan
- Single A packet, idle tx: a_packet_wr with len=1, buf0=0x81 at cycle 0 → tx_packet_wr at cycle 2 with len=1, tx_buf0=0x81, all other bytes 0; a_busy high cycles 1–1 only.
- Simultaneous A and B after reset, A len=3 {81,BA,CE}, B len=5 {81,01,02,03,04}; tx_busy is high 3 cycles after each wr → A issued first, B issued once tx_busy falls, B bytes exact.
- Fairness: keep both slots refilled continuously for 8 grants → grant order strictly alternates A,B,A,B…
- Overflow: while tx_busy is held high, two b_packet_wr strobes → first held, second gives b_drop pulse 1 cycle later; after tx_busy falls only the first packet is emitted.
- tx_busy stuck high at reset release, A packet pending → no tx_packet_wr until tx_busy=0, then issue within 1 cycle.
- Reset asserted in S_BUSY with B pending → all outputs 0 immediately, B never emitted after reset release.

Source files
------------

// File: rtl/tx_arbiter.sv
// Two-port round-robin arbiter sharing one s3g_tx transmitter between the
// command executor (port A) and the event reporter (port B).
module tx_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_packet_wr,
  input  logic [7:0] a_payload_len,
  input  logic [7:0] a_buf0,
  input  logic [7:0] a_buf1,
  input  logic [7:0] a_buf2,
  input  logic [7:0] a_buf3,
  input  logic [7:0] a_buf4,
  input  logic [7:0] a_buf5,
  input  logic [7:0] a_buf6,
  input  logic [7:0] a_buf7,
  input  logic [7:0] a_buf8,
  input  logic [7:0] a_buf9,
  input  logic [7:0] a_buf10,
  input  logic [7:0] a_buf11,
  input  logic [7:0] a_buf12,
  input  logic [7:0] a_buf13,
  input  logic [7:0] a_buf14,
  input  logic [7:0] a_buf15,
  output logic       a_busy,
  output logic       a_drop,
  input  logic       b_packet_wr,
  input  logic [7:0] b_payload_len,
  input  logic [7:0] b_buf0,
  input  logic [7:0] b_buf1,
  input  logic [7:0] b_buf2,
  input  logic [7:0] b_buf3,
  input  logic [7:0] b_buf4,
  input  logic [7:0] b_buf5,
  input  logic [7:0] b_buf6,
  input  logic [7:0] b_buf7,
  input  logic [7:0] b_buf8,
  input  logic [7:0] b_buf9,
  input  logic [7:0] b_buf10,
  input  logic [7:0] b_buf11,
  input  logic [7:0] b_buf12,
  input  logic [7:0] b_buf13,
  input  logic [7:0] b_buf14,
  input  logic [7:0] b_buf15,
  output logic       b_busy,
  output logic       b_drop,
  input  logic       tx_busy,
  output logic       tx_packet_wr,
  output logic [7:0] tx_payload_len,
  output logic [7:0] tx_buf0,
  output logic [7:0] tx_buf1,
  output logic [7:0] tx_buf2,
  output logic [7:0] tx_buf3,
  output logic [7:0] tx_buf4,
  output logic [7:0] tx_buf5,
  output logic [7:0] tx_buf6,
  output logic [7:0] tx_buf7,
  output logic [7:0] tx_buf8,
  output logic [7:0] tx_buf9,
  output logic [7:0] tx_buf10,
  output logic [7:0] tx_buf11,
  output logic [7:0] tx_buf12,
  output logic [7:0] tx_buf13,
  output logic [7:0] tx_buf14,
  output logic [7:0] tx_buf15
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 16;

  typedef struct packed {
    logic [BYTE_W-1:0]                len;
    logic [NUM_BYTES-1:0][BYTE_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t state;
  pkt_t   a_in, b_in;
  pkt_t   a_slot, b_slot;
  pkt_t   tx_pkt;
  logic   last_grant;  // 0: A was granted last, 1: B was granted last
  logic   grant_b_c;

  assign a_in.len  = a_payload_len;
  assign a_in.data = {a_buf15, a_buf14, a_buf13, a_buf12, a_buf11, a_buf10, a_buf9, a_buf8,
                      a_buf7,  a_buf6,  a_buf5,  a_buf4,  a_buf3,  a_buf2,  a_buf1, a_buf0};
  assign b_in.len  = b_payload_len;
  assign b_in.data = {b_buf15, b_buf14, b_buf13, b_buf12, b_buf11, b_buf10, b_buf9, b_buf8,
                      b_buf7,  b_buf6,  b_buf5,  b_buf4,  b_buf3,  b_buf2,  b_buf1, b_buf0};

  // B wins only when A is empty or A had the previous grant
  assign grant_b_c = b_busy && (!a_busy || !last_grant);

  // Slot capture, grant FSM and registered transmitter outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      a_busy       <= 1'b0;
      b_busy       <= 1'b0;
      a_drop       <= 1'b0;
      b_drop       <= 1'b0;
      a_slot       <= '0;
      b_slot       <= '0;
      tx_packet_wr <= 1'b0;
      tx_pkt       <= '0;
    end else begin
      a_drop       <= a_packet_wr && a_busy;
      b_drop       <= b_packet_wr && b_busy;
      tx_packet_wr <= 1'b0;
      tx_pkt       <= '0;

      if (a_packet_wr && !a_busy) begin
        a_busy <= 1'b1;
        a_slot <= a_in;
      end
      if (b_packet_wr && !b_busy) begin
        b_busy <= 1'b1;
        b_slot <= b_in;
      end

      case (state)
        S_IDLE: begin
          if (!tx_busy && (a_busy || b_busy)) begin
            if (grant_b_c) begin
              tx_pkt     <= b_slot;
              b_busy     <= 1'b0;
              last_grant <= 1'b1;
            end else begin
              tx_pkt     <= a_slot;
              a_busy     <= 1'b0;
              last_grant <= 1'b0;
            end
            tx_packet_wr <= 1'b1;
            state        <= S_DELAY;
          end
        end
        // One cycle for s3g_tx to raise tx_busy after the strobe
        S_DELAY: state <= S_BUSY;
        S_BUSY: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign tx_payload_len = tx_pkt.len;
  assign tx_buf0  = tx_pkt.data[0];
  assign tx_buf1  = tx_pkt.data[1];
  assign tx_buf2  = tx_pkt.data[2];
  assign tx_buf3  = tx_pkt.data[3];
  assign tx_buf4  = tx_pkt.data[4];
  assign tx_buf5  = tx_pkt.data[5];
  assign tx_buf6  = tx_pkt.data[6];
  assign tx_buf7  = tx_pkt.data[7];
  assign tx_buf8  = tx_pkt.data[8];
  assign tx_buf9  = tx_pkt.data[9];
  assign tx_buf10 = tx_pkt.data[10];
  assign tx_buf11 = tx_pkt.data[11];
  assign tx_buf12 = tx_pkt.data[12];
  assign tx_buf13 = tx_pkt.data[13];
  assign tx_buf14 = tx_pkt.data[14];
  assign tx_buf15 = tx_pkt.data[15];

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_packet_wr = 1'b0, b_packet_wr = 1'b0, tx_busy = 1'b0;
  logic [7:0] a_len = '0, b_len = '0;
  logic [7:0] a_bytes [16];
  logic [7:0] b_bytes [16];
  logic       a_busy, a_drop, b_busy, b_drop, tx_packet_wr;
  logic [7:0] tx_payload_len;
  logic [7:0] tx_bytes [16];

  int tests = 0;
  int fails = 0;

  // s3g_tx stand-in: raises tx_busy for auto_len cycles after each strobe
  bit auto_tx = 1'b0;
  int auto_len = 3;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  tx_arbiter dut (
    .clk(clk), .rst(rst),
    .a_packet_wr(a_packet_wr), .a_payload_len(a_len),
    .a_buf0(a_bytes[0]),   .a_buf1(a_bytes[1]),   .a_buf2(a_bytes[2]),   .a_buf3(a_bytes[3]),
    .a_buf4(a_bytes[4]),   .a_buf5(a_bytes[5]),   .a_buf6(a_bytes[6]),   .a_buf7(a_bytes[7]),
    .a_buf8(a_bytes[8]),   .a_buf9(a_bytes[9]),   .a_buf10(a_bytes[10]), .a_buf11(a_bytes[11]),
    .a_buf12(a_bytes[12]), .a_buf13(a_bytes[13]), .a_buf14(a_bytes[14]), .a_buf15(a_bytes[15]),
    .a_busy(a_busy), .a_drop(a_drop),
    .b_packet_wr(b_packet_wr), .b_payload_len(b_len),
    .b_buf0(b_bytes[0]),   .b_buf1(b_bytes[1]),   .b_buf2(b_bytes[2]),   .b_buf3(b_bytes[3]),
    .b_buf4(b_bytes[4]),   .b_buf5(b_bytes[5]),   .b_buf6(b_bytes[6]),   .b_buf7(b_bytes[7]),
    .b_buf8(b_bytes[8]),   .b_buf9(b_bytes[9]),   .b_buf10(b_bytes[10]), .b_buf11(b_bytes[11]),
    .b_buf12(b_bytes[12]), .b_buf13(b_bytes[13]), .b_buf14(b_bytes[14]), .b_buf15(b_bytes[15]),
    .b_busy(b_busy), .b_drop(b_drop),
    .tx_busy(tx_busy), .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len),
    .tx_buf0(tx_bytes[0]),   .tx_buf1(tx_bytes[1]),   .tx_buf2(tx_bytes[2]),   .tx_buf3(tx_bytes[3]),
    .tx_buf4(tx_bytes[4]),   .tx_buf5(tx_bytes[5]),   .tx_buf6(tx_bytes[6]),   .tx_buf7(tx_bytes[7]),
    .tx_buf8(tx_bytes[8]),   .tx_buf9(tx_bytes[9]),   .tx_buf10(tx_bytes[10]), .tx_buf11(tx_bytes[11]),
    .tx_buf12(tx_bytes[12]), .tx_buf13(tx_bytes[13]), .tx_buf14(tx_bytes[14]), .tx_buf15(tx_bytes[15])
  );

  // Reference model: one-deep slots, alternating grants, and an issue
  // permission that needs one blind cycle then a sampled tx_busy=0 before it returns.
  logic       m_full [2];
  logic [7:0] m_len  [2];
  logic [7:0] m_pkt  [2][16];
  int         m_last, m_since;
  bit         m_elig;
  logic       e_wr, e_busy_a, e_busy_b, e_drop_a, e_drop_b;
  logic [7:0] e_len;
  logic [7:0] e_bytes [16];

  always @(posedge clk or negedge rst) begin : model
    bit pre_a, pre_b, can;
    int g;
    if (!rst) begin
      m_full[0] = 1'b0; m_full[1] = 1'b0;
      m_last = 1; m_elig = 1'b1; m_since = 0;
      e_wr = 1'b0; e_len = '0;
      e_busy_a = 1'b0; e_busy_b = 1'b0; e_drop_a = 1'b0; e_drop_b = 1'b0;
      for (int i = 0; i < 16; i++) e_bytes[i] = '0;
    end else begin
      pre_a = m_full[0];
      pre_b = m_full[1];
      can   = m_elig && !tx_busy && (pre_a || pre_b);
      g     = (pre_a && pre_b) ? 1 - m_last : (pre_a ? 0 : 1);
      e_wr  = can;
      e_len = can ? m_len[g] : 8'h00;
      for (int i = 0; i < 16; i++) e_bytes[i] = can ? m_pkt[g][i] : 8'h00;
      e_drop_a = a_packet_wr && pre_a;
      e_drop_b = b_packet_wr && pre_b;
      if (can) begin
        m_full[g] = 1'b0; m_last = g; m_elig = 1'b0; m_since = 0;
      end else begin
        if (!m_elig && m_since >= 1 && !tx_busy) m_elig = 1'b1;
        m_since++;
      end
      if (a_packet_wr && !pre_a) begin
        m_full[0] = 1'b1; m_len[0] = a_len;
        for (int i = 0; i < 16; i++) m_pkt[0][i] = a_bytes[i];
      end
      if (b_packet_wr && !pre_b) begin
        m_full[1] = 1'b1; m_len[1] = b_len;
        for (int i = 0; i < 16; i++) m_pkt[1][i] = b_bytes[i];
      end
      e_busy_a = m_full[0];
      e_busy_b = m_full[1];
    end
  end

  logic [140:0] obs, expv;
  always_comb begin
    obs = {tx_packet_wr, tx_payload_len, 128'(0), a_busy, b_busy, a_drop, b_drop};
    for (int i = 0; i < 16; i++) obs[4 + i*8 +: 8] = tx_bytes[i];
  end
  always_comb begin
    expv = {e_wr, e_len, 128'(0), e_busy_a, e_busy_b, e_drop_a, e_drop_b};
    for (int i = 0; i < 16; i++) expv[4 + i*8 +: 8] = e_bytes[i];
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    a_packet_wr = 1'b0;
    b_packet_wr = 1'b0;
    if (auto_tx) begin
      if (tx_packet_wr) busy_cnt = auto_len;
      tx_busy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
    a_packet_wr = 1'b0; b_packet_wr = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_values: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL reset_idle c%0d: got %h expected %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_single_a();
    auto_tx = 1'b1; auto_len = 3;
    a_len = 8'd1;
    for (int i = 0; i < 16; i++) a_bytes[i] = 8'h00;
    a_bytes[0] = 8'h81;
    a_packet_wr = 1'b1;
    cycle();
    tests++;
    if (a_busy !== 1'b1 || tx_packet_wr !== 1'b0) begin
      fails++; $display("FAIL single_a_capture: got busy=%b wr=%b expected busy=1 wr=0", a_busy, tx_packet_wr);
    end
    cycle();
    tests++;
    if (tx_packet_wr !== 1'b1 || tx_payload_len !== 8'd1 || tx_bytes[0] !== 8'h81 || a_busy !== 1'b0) begin
      fails++; $display("FAIL single_a_issue: got wr=%b len=%h b0=%h busy=%b expected 1/01/81/0",
                        tx_packet_wr, tx_payload_len, tx_bytes[0], a_busy);
    end
    for (int c = 0; c < 6; c++) begin
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL single_a c%0d: got %h expected %h", c, obs, expv);
      end
      cycle();
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] seen [$];
    logic [39:0] b_got;
    reset_pulse();
    auto_tx = 1'b1; auto_len = 3;
    a_len = 8'd3; b_len = 8'd5;
    for (int i = 0; i < 16; i++) begin a_bytes[i] = 8'h00; b_bytes[i] = 8'h00; end
    a_bytes[0] = 8'h81; a_bytes[1] = 8'hBA; a_bytes[2] = 8'hCE;
    b_bytes[0] = 8'h81; b_bytes[1] = 8'h01; b_bytes[2] = 8'h02; b_bytes[3] = 8'h03; b_bytes[4] = 8'h04;
    a_packet_wr = 1'b1; b_packet_wr = 1'b1;
    for (int c = 0; c < 14; c++) begin
      cycle();
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL simultaneous c%0d: got %h expected %h", c, obs, expv);
      end
      if (tx_packet_wr === 1'b1) begin
        seen.push_back(tx_payload_len);
        if (seen.size() == 2) begin
          b_got = {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3], tx_bytes[4]};
          tests++;
          if (b_got !== 40'h8101020304) begin
            fails++; $display("FAIL simultaneous_b_bytes: got %h expected 8101020304", b_got);
          end
        end
      end
    end
    tests++;
    if (seen.size() != 2 || seen[0] !== 8'd3 || seen[1] !== 8'd5) begin
      fails++; $display("FAIL simultaneous_order: got %0d pulses expected 2 (A len3 then B len5)", seen.size());
    end
  endtask

  task automatic test_fairness();
    logic [3:0] order [$];
    reset_pulse();
    auto_tx = 1'b1;
    for (int c = 0; c < 300 && order.size() < 8; c++) begin
      auto_len = $urandom_range(0, 3);
      a_len = {4'hA, 4'($urandom)};
      b_len = {4'hB, 4'($urandom)};
      for (int i = 0; i < 16; i++) begin a_bytes[i] = 8'($urandom); b_bytes[i] = 8'($urandom); end
      a_packet_wr = 1'b1; b_packet_wr = 1'b1;
      cycle();
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL fairness c%0d: got %h expected %h", c, obs, expv);
      end
      if (tx_packet_wr === 1'b1) order.push_back(tx_payload_len[7:4]);
    end
    tests++;
    if (order.size() < 8) begin
      fails++; $display("FAIL fairness_count: got %0d grants expected 8", order.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (order[i] !== ((i % 2 == 0) ? 4'hA : 4'hB)) begin
          fails++; $display("FAIL fairness_order[%0d]: got %h expected %h", i, order[i], (i % 2 == 0) ? 4'hA : 4'hB);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] first [16];
    int pulses = 0;
    reset_pulse();
    auto_tx = 1'b0; tx_busy = 1'b1;
    b_len = 8'd7;
    for (int i = 0; i < 16; i++) begin b_bytes[i] = 8'($urandom); first[i] = b_bytes[i]; end
    b_packet_wr = 1'b1;
    cycle();
    tests++;
    if (b_busy !== 1'b1 || b_drop !== 1'b0) begin
      fails++; $display("FAIL overflow_first: got busy=%b drop=%b expected 1/0", b_busy, b_drop);
    end
    b_len = 8'd9;
    for (int i = 0; i < 16; i++) b_bytes[i] = 8'($urandom);
    b_packet_wr = 1'b1;
    cycle();
    tests++;
    if (b_drop !== 1'b1) begin
      fails++; $display("FAIL overflow_drop: got b_drop=%b expected 1", b_drop);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests++;
      if (obs !== expv || b_drop !== 1'b0 || tx_packet_wr !== 1'b0) begin
        fails++; $display("FAIL overflow_hold c%0d: got %h expected %h", c, obs, expv);
      end
    end
    tx_busy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL overflow_drain c%0d: got %h expected %h", c, obs, expv);
      end
      if (tx_packet_wr === 1'b1) begin
        pulses++;
        for (int i = 0; i < 16; i++) begin
          tests++;
          if (tx_bytes[i] !== first[i] || tx_payload_len !== 8'd7) begin
            fails++; $display("FAIL overflow_data[%0d]: got %h len %h expected %h len 07",
                              i, tx_bytes[i], tx_payload_len, first[i]);
          end
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL overflow_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_stuck_busy();
    auto_tx = 1'b0;
    rst = 1'b0; tx_busy = 1'b1; busy_cnt = 0;
    cycle();
    rst = 1'b1;
    a_len = 8'd2;
    for (int i = 0; i < 16; i++) a_bytes[i] = 8'($urandom);
    a_packet_wr = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      tests++;
      if (tx_packet_wr !== 1'b0 || obs !== expv) begin
        fails++; $display("FAIL stuck_busy c%0d: got %h expected %h", c, obs, expv);
      end
    end
    tx_busy = 1'b0;
    cycle();
    tests++;
    if (tx_packet_wr !== 1'b1 || tx_payload_len !== 8'd2) begin
      fails++; $display("FAIL stuck_release: got wr=%b len=%h expected 1/02", tx_packet_wr, tx_payload_len);
    end
  endtask

  task automatic test_reset_mid();
    reset_pulse();
    auto_tx = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin a_bytes[i] = 8'($urandom); b_bytes[i] = 8'($urandom); end
    a_len = 8'd4; b_len = 8'd6;
    a_packet_wr = 1'b1; b_packet_wr = 1'b1;
    cycle();
    cycle();
    tx_busy = 1'b1;
    cycle();
    cycle();
    tests++;
    if (b_busy !== 1'b1) begin
      fails++; $display("FAIL reset_mid_pending: got b_busy=%b expected 1", b_busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_mid_async: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b1; tx_busy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      tests++;
      if (tx_packet_wr !== 1'b0 || obs !== expv) begin
        fails++; $display("FAIL reset_mid_after c%0d: got %h expected %h", c, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    reset_pulse();
    auto_tx = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) auto_len = $urandom_range(0, 4);
      a_packet_wr = ($urandom_range(0, 2) == 0);
      b_packet_wr = ($urandom_range(0, 2) == 0);
      a_len = 8'($urandom);
      b_len = 8'($urandom);
      for (int i = 0; i < 16; i++) begin a_bytes[i] = 8'($urandom); b_bytes[i] = 8'($urandom); end
      cycle();
      tests++;
      if (obs !== expv) begin
        fails++; $display("FAIL random c%0d: got %h expected %h", c, obs, expv);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin a_bytes[i] = '0; b_bytes[i] = '0; end
    test_reset();
    test_single_a();
    test_simultaneous();
    test_fairness();
    test_overflow();
    test_stuck_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
